gated_word_sender: RTL and testbench

- Source end of the gated-capture register interface. Accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Replays each word onto a parallel data bus with a one-cycle enable strobe, spaced by a programmable idle gap.
- Downstream consumers are clock-enabled registers: one capture per O_EN pulse. The downstream clock is never gated.
- Sits between board-level stimulus logic and the capture registers.

---
 rtl/gated_word_sender_pkg.sv | 15 +
 rtl/gated_word_sender_sync_fifo.sv | 52 +++++
 rtl/gated_word_sender.sv | 100 ++++++++++
 tb/tb_gated_word_sender.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gated_word_sender_pkg.sv
// Shared types and defaults for the gated word sender and its FIFO.
// State names carry an S_ prefix so they never collide with the GAP parameter.
package gated_word_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_GAP   = 2;
   localparam int GAP_CNT_W = 4;

   typedef enum logic {
      S_IDLE,
      S_GAP
   } gw_state_t;

endpackage

// File: rtl/gated_word_sender_sync_fifo.sv
// Small synchronous FIFO: power-of-two storage, wrapping pointers and a separate occupancy counter.
module sync_fifo
   import gated_word_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     CLK,
   input  logic                     RESETN,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap on their own; count tracks occupancy so full and empty stay distinct.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/gated_word_sender.sv
// Replays buffered words onto a parallel bus, one capture strobe per word, spaced by a fixed idle gap.
module gated_word_sender
   import gated_word_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int GAP   = DEF_GAP
) (
   input  logic                     CLK,
   input  logic                     RESETN,
   input  logic [WIDTH-1:0]         I,
   input  logic                     I_VALID,
   output logic                     I_READY,
   output logic [WIDTH-1:0]         O,
   output logic                     O_EN,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     BUSY
);

   localparam int                   CW         = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'(GAP);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST   = GAP_CNT_W'(1);

   gw_state_t            state;
   gw_state_t            state_nxt;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [GAP_CNT_W-1:0] gap_cnt_nxt;
   logic [WIDTH-1:0]     o_nxt;
   logic                 o_en_nxt;
   logic                 push;
   logic                 pop;
   logic [WIDTH-1:0]     head;
   logic [CW-1:0]        count;

   // Readiness looks only at registered occupancy, so a full FIFO refuses even while popping.
   assign I_READY = (count != FULL_COUNT);
   assign push    = I_VALID && I_READY;
   assign COUNT   = count;
   assign BUSY    = (count != '0) || (state != S_IDLE) || O_EN;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .push      (push),
      .push_data (I),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state   <= S_IDLE;
         gap_cnt <= '0;
         O       <= '0;
         O_EN    <= 1'b0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
         O       <= o_nxt;
         O_EN    <= o_en_nxt;
      end
   end

   // A strobe only launches from IDLE; O is reloaded solely on strobe edges and otherwise holds.
   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      o_nxt       = O;
      o_en_nxt    = 1'b0;
      pop         = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop      = 1'b1;
               o_nxt    = head;
               o_en_nxt = 1'b1;
               if (GAP > 0) begin
                  gap_cnt_nxt = GAP_LOAD;
                  state_nxt   = S_GAP;
               end
            end
         end
         S_GAP: begin
            gap_cnt_nxt = gap_cnt - 1'b1;
            if (gap_cnt == GAP_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gated_word_sender.sv
// Bench for gated_word_sender: two instances (GAP=2 and GAP=0) share stimulus and are checked
// every cycle against a queue-based model, with literal expectations pinning key moments.
module tb_gated_word_sender;

   localparam int DEPTH = 4;

   logic             CLK     = 1'b0;
   logic             RESETN  = 1'b0;
   logic [3:0]       I       = '0;
   logic             I_VALID = 1'b0;

   logic [1:0]       rdy;
   logic [1:0][3:0]  o;
   logic [1:0]       en;
   logic [1:0][2:0]  cnt;
   logic [1:0]       busy;

   int               compared   = 0;
   int               mismatched = 0;
   bit               chk_en     = 1'b0;

   int               msize [2] = '{0, 0};
   int               mhead [2] = '{0, 0};
   int               cool  [2] = '{0, 0};
   logic [3:0]       mbuf  [2][16];
   logic [3:0]       exp_o [2] = '{4'h0, 4'h0};
   logic             exp_en[2] = '{1'b0, 1'b0};

   gated_word_sender #(.WIDTH(4), .DEPTH(DEPTH), .GAP(2)) dut_gap2 (
      .CLK(CLK), .RESETN(RESETN), .I(I), .I_VALID(I_VALID), .I_READY(rdy[0]),
      .O(o[0]), .O_EN(en[0]), .COUNT(cnt[0]), .BUSY(busy[0])
   );

   gated_word_sender #(.WIDTH(4), .DEPTH(DEPTH), .GAP(0)) dut_gap0 (
      .CLK(CLK), .RESETN(RESETN), .I(I), .I_VALID(I_VALID), .I_READY(rdy[1]),
      .O(o[1]), .O_EN(en[1]), .COUNT(cnt[1]), .BUSY(busy[1])
   );

   always #5 CLK = ~CLK;

   function automatic int gapOf(int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic bit modelReady(int k);
      return msize[k] != DEPTH;
   endfunction

   // A word may leave once the previous strobe's cooldown has elapsed and something is queued.
   function automatic bit modelPop(int k);
      return (cool[k] == 0) && (msize[k] != 0);
   endfunction

   always @(posedge CLK or negedge RESETN) begin
      for (int k = 0; k < 2; k++) begin
         if (!RESETN) begin
            msize[k]  <= 0;
            mhead[k]  <= 0;
            cool[k]   <= 0;
            exp_o[k]  <= 4'h0;
            exp_en[k] <= 1'b0;
         end else begin
            if (I_VALID && modelReady(k)) begin
               mbuf[k][(mhead[k] + msize[k]) % 16] <= I;
            end
            msize[k] <= msize[k] + int'(I_VALID && modelReady(k)) - int'(modelPop(k));
            if (modelPop(k)) begin
               exp_o[k]  <= mbuf[k][mhead[k]];
               exp_en[k] <= 1'b1;
               mhead[k]  <= (mhead[k] + 1) % 16;
               cool[k]   <= gapOf(k);
            end else begin
               exp_en[k] <= 1'b0;
               if (cool[k] > 0) begin
                  cool[k] <= cool[k] - 1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, expv);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("model_o[%0d]", k), o[k], exp_o[k]);
            checkOutput($sformatf("model_en[%0d]", k), en[k], exp_en[k]);
            checkOutput($sformatf("model_count[%0d]", k), cnt[k], msize[k]);
            checkOutput($sformatf("model_ready[%0d]", k), rdy[k], modelReady(k));
            checkOutput($sformatf("model_busy[%0d]", k), busy[k],
                        (msize[k] != 0) || (cool[k] != 0) || exp_en[k]);
         end
      end
   end

   // One cycle: drive inputs just after the falling edge, return at the next falling edge.
   task automatic applyStimulus(input logic valid, input logic [3:0] data);
      #1;
      I_VALID = valid;
      I       = data;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      chk_en = 1'b1;
      applyStimulus(1'b1, 4'hF);
      applyStimulus(1'b1, 4'hF);
      checkOutput("rst_o", o[0], 4'h0);
      checkOutput("rst_en", en[0], 1'b0);
      checkOutput("rst_count", cnt[0], 0);
      checkOutput("rst_ready", rdy[0], 1'b1);
      #1 RESETN = 1'b1;
      applyStimulus(1'b0, 4'h0);
      checkOutput("rst_nothing_queued", cnt[0], 0);

      applyStimulus(1'b1, 4'h3);
      checkOutput("lat_no_early_en", en[0], 1'b0);
      checkOutput("lat_count", cnt[0], 1);
      applyStimulus(1'b0, 4'h0);
      checkOutput("lat_en", en[0], 1'b1);
      checkOutput("lat_o", o[0], 4'h3);
      applyStimulus(1'b0, 4'h0);
      checkOutput("gap1_en", en[0], 1'b0);
      checkOutput("gap1_busy", busy[0], 1'b1);
      applyStimulus(1'b0, 4'h0);
      checkOutput("gap2_en", en[0], 1'b0);
      checkOutput("gap2_o_hold", o[0], 4'h3);
      checkOutput("gap2_busy", busy[0], 1'b0);
      applyStimulus(1'b0, 4'h0);

      applyStimulus(1'b1, 4'h1);
      checkOutput("b2b_first_en", en[1], 1'b0);
      applyStimulus(1'b1, 4'h2);
      checkOutput("b2b_o1", o[1], 4'h1);
      applyStimulus(1'b1, 4'h3);
      checkOutput("b2b_o2", o[1], 4'h2);
      checkOutput("b2b_en2", en[1], 1'b1);
      applyStimulus(1'b0, 4'h0);
      checkOutput("b2b_o3", o[1], 4'h3);
      checkOutput("b2b_en3", en[1], 1'b1);
      applyStimulus(1'b0, 4'h0);
      checkOutput("b2b_en_off", en[1], 1'b0);
      repeat (6) applyStimulus(1'b0, 4'h0);

      applyStimulus(1'b1, 4'hA);
      applyStimulus(1'b1, 4'hB);
      checkOutput("fill_oA", o[0], 4'hA);
      applyStimulus(1'b1, 4'hC);
      applyStimulus(1'b1, 4'hD);
      checkOutput("fill_count3", cnt[0], 3);
      applyStimulus(1'b1, 4'hE);
      checkOutput("fill_oB", o[0], 4'hB);
      applyStimulus(1'b1, 4'h6);
      checkOutput("full_count", cnt[0], 4);
      checkOutput("full_ready", rdy[0], 1'b0);
      applyStimulus(1'b1, 4'h7);
      checkOutput("full_reject_count", cnt[0], 4);
      applyStimulus(1'b1, 4'h7);
      checkOutput("pop_reject_count", cnt[0], 3);
      checkOutput("pop_reject_oC", o[0], 4'hC);
      checkOutput("pop_reject_ready", rdy[0], 1'b1);
      applyStimulus(1'b1, 4'h7);
      checkOutput("retry_count", cnt[0], 4);
      applyStimulus(1'b0, 4'h0);
      applyStimulus(1'b0, 4'h0);
      checkOutput("pre_rst_oD", o[0], 4'hD);
      checkOutput("pre_rst_en", en[0], 1'b1);
      checkOutput("pre_rst_count", cnt[0], 3);

      #2 RESETN = 1'b0;
      #1;
      checkOutput("async_rst_o", o[0], 4'h0);
      checkOutput("async_rst_en", en[0], 1'b0);
      checkOutput("async_rst_count", cnt[0], 0);
      checkOutput("async_rst_busy", busy[0], 1'b0);
      applyStimulus(1'b0, 4'h0);
      #1 RESETN = 1'b1;
      repeat (4) applyStimulus(1'b0, 4'h0);
      checkOutput("post_rst_en", en[0], 1'b0);
      checkOutput("post_rst_count", cnt[0], 0);
      applyStimulus(1'b1, 4'h5);
      applyStimulus(1'b0, 4'h0);
      checkOutput("post_rst_o5", o[0], 4'h5);
      checkOutput("post_rst_en5", en[0], 1'b1);
      repeat (4) applyStimulus(1'b0, 4'h0);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
